// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, instruction classes, control
// flag bundle and helpers for classification and register index validity.
package decode_pkg;

   // Physical register slots (address field is 5 bits); slots at or above
   // the configured register count never get written and always read zero.
   localparam int REG_SLOTS = 32;

   localparam logic [6:0] OP_LW = 7'h10;
   localparam logic [6:0] OP_LB = 7'h11;
   localparam logic [6:0] OP_SW = 7'h12;
   localparam logic [6:0] OP_SB = 7'h13;
   localparam logic [6:0] OP_BR = 7'h30;
   // ALU-immediate opcodes occupy 0x20..0x2F
   localparam logic [2:0] OP_ALUI_HI = 3'b010;

   typedef enum logic [2:0] {
      CLS_ALU_REG,
      CLS_ALU_IMM,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH
   } op_class_e;

   typedef struct packed {
      logic y_sel;
      logic rd_mem;
      logic wr_mem;
      logic is_byte;
      logic wr_reg;
      logic branch;
      logic load;
   } ctrl_t;

   function automatic op_class_e classify(input logic [6:0] op);
      if (op == OP_LW || op == OP_LB) return CLS_LOAD;
      if (op == OP_SW || op == OP_SB) return CLS_STORE;
      if (op == OP_BR)                return CLS_BRANCH;
      if (op[6:4] == OP_ALUI_HI)      return CLS_ALU_IMM;
      return CLS_ALU_REG;
   endfunction

   function automatic ctrl_t decode_ctrl(input logic [6:0] op, input logic [4:0] rd);
      ctrl_t     c;
      op_class_e cls;
      c   = '0;
      cls = classify(op);
      case (cls)
         CLS_LOAD: begin
            c.rd_mem  = 1'b1;
            c.load    = 1'b1;
            c.y_sel   = 1'b1;
            c.is_byte = (op == OP_LB);
         end
         CLS_STORE: begin
            c.wr_mem  = 1'b1;
            c.y_sel   = 1'b1;
            c.is_byte = (op == OP_SB);
         end
         CLS_BRANCH: begin
            c.branch = 1'b1;
            c.y_sel  = 1'b1;
         end
         CLS_ALU_IMM: c.y_sel = 1'b1;
         default: ;
      endcase
      c.wr_reg = (cls != CLS_STORE) && (cls != CLS_BRANCH) && (rd != 5'd0);
      return c;
   endfunction

   // True for a register that really exists and is writable (not r0, below count)
   function automatic logic idx_ok(input logic [4:0] a, input int n);
      return (a != 5'd0) && (32'(a) < 32'(n));
   endfunction

endpackage

// File: rtl/reg_bank_param.sv
// Register bank: NREGS x DATA_W, two asynchronous read ports, one write port.
// r0 and indices >= NREGS read as zero and ignore writes. With BYPASS != 0 a
// read that matches the write in flight returns the write data.
// Ports: clk, reset (async, active-low), rd_addr_a/rd_data_a,
//        rd_addr_b/rd_data_b, wr_en/wr_addr/wr_data.
module reg_bank_param
   import decode_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [4:0]        rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam logic BYP = (BYPASS != 0);

   logic [DATA_W-1:0] regs_q [REG_SLOTS];
   logic [DATA_W-1:0] regs_d [REG_SLOTS];
   logic              wr_ok;

   assign wr_ok = wr_en && idx_ok(wr_addr, NREGS);

   always_comb begin
      regs_d = regs_q;
      if (wr_ok) regs_d[wr_addr] = wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REG_SLOTS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd_data_a = regs_q[rd_addr_a];
      if (!idx_ok(rd_addr_a, NREGS))            rd_data_a = '0;
      else if (BYP && wr_ok && wr_addr == rd_addr_a) rd_data_a = wr_data;
   end

   always_comb begin
      rd_data_b = regs_q[rd_addr_b];
      if (!idx_ok(rd_addr_b, NREGS))            rd_data_b = '0;
      else if (BYP && wr_ok && wr_addr == rd_addr_b) rd_data_b = wr_data;
   end

endmodule

// File: rtl/decode_pipe.sv
// Instruction decode stage: splits the instruction word into fields, reads
// operands, tracks outstanding register writes with a pending scoreboard and
// presents the decoded instruction in a single registered output slot.
// Ports: clk, reset (async, active-low); in_valid/in_ready/in_ir accept side;
//        flush kills the output slot; wb_* write-back/release events;
//        out_valid/out_ready plus registered out_* decode results.
// DATA_W must be at least 16 (the immediate is 15 bits before extension).
module decode_pipe
   import decode_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [31:0]       in_ir,
   output logic              in_ready,
   input  logic              flush,
   input  logic              wb_valid,
   input  logic              wb_we,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [6:0]        out_op,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [DATA_W-1:0] out_immed,
   output logic [4:0]        out_addr_a,
   output logic [4:0]        out_addr_b,
   output logic [4:0]        out_addr_d,
   output logic              out_y_sel,
   output logic              out_rd_mem,
   output logic              out_wr_mem,
   output logic              out_byte,
   output logic              out_wr_reg,
   output logic              out_branch,
   output logic              out_load
);

   localparam logic BYP = (BYPASS != 0);

   typedef struct packed {
      logic [6:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] imm;
      logic [4:0]        addr_a;
      logic [4:0]        addr_b;
      logic [4:0]        addr_d;
      ctrl_t             ctrl;
   } slot_t;

   slot_t                slot_q, slot_d;
   logic                 out_valid_q, out_valid_d;
   logic [REG_SLOTS-1:0] pend_q, pend_d;

   logic [6:0]        dec_op;
   logic [4:0]        dec_rd, dec_ra, dec_rb;
   logic [DATA_W-1:0] dec_imm, rd_a, rd_b;
   ctrl_t             dec_ctrl;
   logic [REG_SLOTS-1:0] clr_vec;
   logic              uses_rb, haz_a, haz_b, haz_d, slot_free, accept;

   assign dec_op   = in_ir[31:25];
   assign dec_rd   = in_ir[24:20];
   assign dec_ra   = in_ir[19:15];
   assign dec_rb   = in_ir[14:10];
   assign dec_imm  = {{(DATA_W-15){in_ir[14]}}, in_ir[14:0]};
   assign dec_ctrl = decode_ctrl(dec_op, dec_rd);
   // rb is a real source for register-form ops and as store data
   assign uses_rb  = !dec_ctrl.y_sel || dec_ctrl.wr_mem;

   reg_bank_param #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
   ) u_regs (
      .clk       (clk),
      .reset     (reset),
      .rd_addr_a (dec_ra),
      .rd_data_a (rd_a),
      .rd_addr_b (dec_rb),
      .rd_data_b (rd_b),
      .wr_en     (wb_valid && wb_we),
      .wr_addr   (wb_addr),
      .wr_data   (wb_data)
   );

   always_comb begin
      clr_vec = '0;
      if (wb_valid) clr_vec[wb_addr] = 1'b1;
   end

   // A source being released this cycle can only be read without stalling when
   // the bank forwards the write data. rd only guards against a second writer,
   // so a release this cycle is always enough for it.
   assign haz_a = pend_q[dec_ra] && !(clr_vec[dec_ra] && BYP);
   assign haz_b = uses_rb && pend_q[dec_rb] && !(clr_vec[dec_rb] && BYP);
   assign haz_d = dec_ctrl.wr_reg && pend_q[dec_rd] && !clr_vec[dec_rd];

   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = reset && !flush && slot_free && !(haz_a || haz_b || haz_d);
   assign accept    = in_valid && in_ready;

   always_comb begin
      slot_d      = slot_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d   = 1'b1;
         slot_d.op     = dec_op;
         slot_d.a      = rd_a;
         slot_d.b      = rd_b;
         slot_d.imm    = dec_imm;
         slot_d.addr_a = dec_ra;
         slot_d.addr_b = dec_rb;
         slot_d.addr_d = dec_rd;
         slot_d.ctrl   = dec_ctrl;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Order matters: a new claim on a register wins over a release of it.
   always_comb begin
      pend_d = pend_q;
      if (wb_valid) pend_d[wb_addr] = 1'b0;
      if (flush && out_valid_q && slot_q.ctrl.wr_reg) pend_d[slot_q.addr_d] = 1'b0;
      if (accept && dec_ctrl.wr_reg && idx_ok(dec_rd, NREGS)) pend_d[dec_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q      <= '0;
         out_valid_q <= 1'b0;
         pend_q      <= '0;
      end else begin
         slot_q      <= slot_d;
         out_valid_q <= out_valid_d;
         pend_q      <= pend_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_op     = slot_q.op;
   assign out_a      = slot_q.a;
   assign out_b      = slot_q.b;
   assign out_immed  = slot_q.imm;
   assign out_addr_a = slot_q.addr_a;
   assign out_addr_b = slot_q.addr_b;
   assign out_addr_d = slot_q.addr_d;
   assign out_y_sel  = slot_q.ctrl.y_sel;
   assign out_rd_mem = slot_q.ctrl.rd_mem;
   assign out_wr_mem = slot_q.ctrl.wr_mem;
   assign out_byte   = slot_q.ctrl.is_byte;
   assign out_wr_reg = slot_q.ctrl.wr_reg;
   assign out_branch = slot_q.ctrl.branch;
   assign out_load   = slot_q.ctrl.load;

endmodule
